// File: rtl/addr_rf_scheduler.sv
// Frame-level raster scheduler in front of AddrToRF: issues each strided (h,w) position,
// waits for the fetch to finish, then hands the position to the MAC stage over valid/ready.
// Optional WAIT watchdog enabled by defining ADDR_RF_SCHED_TIMEOUT_EN.
module addr_rf_scheduler #(
    parameter int POS_BW  = 7,
    parameter int STR_BW  = 3,
    parameter int TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [POS_BW-1:0] i_height,
    input  logic [POS_BW-1:0] i_width,
    input  logic [STR_BW-1:0] i_stride,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rf_start,
    output logic [POS_BW-1:0] o_rf_h,
    output logic [POS_BW-1:0] o_rf_w,
    input  logic              i_rf_finish,
    output logic              o_pos_valid,
    input  logic              i_pos_ready,
    output logic [13:0]       o_pos_idx,
    output logic              o_timeout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_HAND  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [POS_BW-1:0] cfg_h;
    logic [POS_BW-1:0] cfg_w;
    logic [STR_BW-1:0] cfg_s;
    logic [POS_BW-1:0] pos_h;
    logic [POS_BW-1:0] pos_w;
    logic [13:0]       idx;

    logic [POS_BW:0]   w_sum;
    logic [POS_BW:0]   h_sum;
    logic              w_wrap;
    logic              h_end;
    logic              scan_end;
    logic              accept;
    logic              xfer;
    logic              abort;
    logic              advance;

    function automatic logic [STR_BW-1:0] norm_stride(input logic [STR_BW-1:0] s);
        return (s == '0) ? STR_BW'(1) : s;
    endfunction

    function automatic logic [13:0] sat_inc(input logic [13:0] v);
        return (&v) ? v : v + 14'd1;
    endfunction

    // Sums are one bit wider than the coordinates so a large stride can never wrap past the bound.
    assign w_sum    = {1'b0, pos_w} + (POS_BW+1)'(cfg_s);
    assign h_sum    = {1'b0, pos_h} + (POS_BW+1)'(cfg_s);
    assign w_wrap   = (w_sum >= {1'b0, cfg_w});
    assign h_end    = (h_sum >= {1'b0, cfg_h});
    assign scan_end = w_wrap && h_end;

    assign accept  = (state == S_IDLE) && i_start;
    assign xfer    = (state == S_HAND) && i_pos_ready;
    assign advance = xfer || abort;

`ifdef ADDR_RF_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;

    // A finish arriving on the last allowed WAIT cycle still takes priority over the abort.
    assign abort = (state == S_WAIT) && !i_rf_finish && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= abort;
            if (state == S_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    assign o_timeout = timeout_q;
`else
    assign abort     = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = ((i_height == '0) || (i_width == '0)) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (i_rf_finish) begin
                    state_nxt = S_HAND;
                end else if (abort) begin
                    state_nxt = scan_end ? S_DONE : S_ISSUE;
                end
            end
            S_HAND: begin
                if (i_pos_ready) begin
                    state_nxt = scan_end ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy      = 1'b1;
        o_done      = 1'b0;
        o_rf_start  = 1'b0;
        o_pos_valid = 1'b0;
        case (state)
            S_IDLE:  o_busy      = 1'b0;
            S_ISSUE: o_rf_start  = 1'b1;
            S_HAND:  o_pos_valid = 1'b1;
            S_DONE:  o_done      = 1'b1;
            default: ;
        endcase
    end

    // Config, position and hand-off count; position only moves on a transfer or an abort.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cfg_h <= '0;
            cfg_w <= '0;
            cfg_s <= '0;
            pos_h <= '0;
            pos_w <= '0;
            idx   <= '0;
        end else if (accept) begin
            cfg_h <= i_height;
            cfg_w <= i_width;
            cfg_s <= norm_stride(i_stride);
            pos_h <= '0;
            pos_w <= '0;
            idx   <= '0;
        end else begin
            if (advance) begin
                if (!w_wrap) begin
                    pos_w <= w_sum[POS_BW-1:0];
                end else begin
                    pos_w <= '0;
                    if (!h_end) begin
                        pos_h <= h_sum[POS_BW-1:0];
                    end
                end
            end
            if (xfer) begin
                idx <= sat_inc(idx);
            end
        end
    end

    assign o_rf_h    = pos_h;
    assign o_rf_w    = pos_w;
    assign o_pos_idx = idx;

endmodule

// File: tb/tb_addr_rf_scheduler.sv
// Randomized bench for addr_rf_scheduler: the expected position list is built from nested
// strided loops and compared against every rf_start and every valid/ready transfer.
module tb_addr_rf_scheduler;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [6:0]  i_height;
    logic [6:0]  i_width;
    logic [2:0]  i_stride;
    logic        o_busy;
    logic        o_done;
    logic        o_rf_start;
    logic [6:0]  o_rf_h;
    logic [6:0]  o_rf_w;
    logic        i_rf_finish;
    logic        o_pos_valid;
    logic        i_pos_ready;
    logic [13:0] o_pos_idx;
    logic        o_timeout;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    addr_rf_scheduler #(.POS_BW(7), .STR_BW(3), .TIMEOUT(64)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_height    (i_height),
        .i_width     (i_width),
        .i_stride    (i_stride),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_rf_start  (o_rf_start),
        .o_rf_h      (o_rf_h),
        .o_rf_w      (o_rf_w),
        .i_rf_finish (i_rf_finish),
        .o_pos_valid (o_pos_valid),
        .i_pos_ready (i_pos_ready),
        .o_pos_idx   (o_pos_idx),
        .o_timeout   (o_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Runs one frame; skip is the index of the position whose fetch never finishes (-1: none).
    task automatic run_frame(input int H, input int W, input int S, input int rdy_pct,
                             input int skip, input int fin_max);
        int  s_eff;
        int  fh[$];
        int  fw[$];
        int  vh[$];
        int  vw[$];
        int  nstart  = 0;
        int  ntr     = 0;
        int  fin_cnt = -1;
        int  to_cyc  = -100;
        int  cyc     = 0;
        int  ph      = 0;
        int  pw      = 0;
        bit  stall   = 1'b0;
        bit  done_seen = 1'b0;
        bit  rdy;

        s_eff = (S == 0) ? 1 : S;
        for (int h = 0; h < H; h += s_eff) begin
            for (int w = 0; w < W; w += s_eff) begin
                if (fh.size() != skip) begin
                    vh.push_back(h);
                    vw.push_back(w);
                end
                fh.push_back(h);
                fw.push_back(w);
            end
        end

        i_height = 7'(H);
        i_width  = 7'(W);
        i_stride = 3'(S);
        i_start  = 1'b1;
        tick();
        i_start  = 1'b0;

        while (!done_seen && cyc < 5000) begin
            chk("busy_in_frame", o_busy, 1);
            chk("timeout_pulse", o_timeout, (cyc == to_cyc));
            if (stall) begin
                chk("stall_valid", o_pos_valid, 1);
                chk("stall_h", o_rf_h, ph);
                chk("stall_w", o_rf_w, pw);
            end
            if (o_rf_start) begin
                chk("start_excl_valid", o_pos_valid, 0);
                chk("start_in_range", (nstart < fh.size()), 1);
                if (nstart < fh.size()) begin
                    chk("start_h", o_rf_h, fh[nstart]);
                    chk("start_w", o_rf_w, fw[nstart]);
                end
                if (nstart == skip) begin
                    fin_cnt = -1;
                    to_cyc  = cyc + 65;
                end else begin
                    fin_cnt = $urandom_range(fin_max, 1);
                end
                nstart++;
            end else if (fin_cnt >= 0) begin
                fin_cnt--;
            end
            i_rf_finish = (fin_cnt == 0);

            rdy = ($urandom_range(99, 0) < rdy_pct);
            i_pos_ready = rdy;
            stall = 1'b0;
            if (o_pos_valid) begin
                if (rdy) begin
                    chk("xfer_in_range", (ntr < vh.size()), 1);
                    if (ntr < vh.size()) begin
                        chk("xfer_h", o_rf_h, vh[ntr]);
                        chk("xfer_w", o_rf_w, vw[ntr]);
                    end
                    chk("xfer_idx", o_pos_idx, ntr);
                    ntr++;
                end else begin
                    stall = 1'b1;
                    ph = o_rf_h;
                    pw = o_rf_w;
                end
            end

            if (o_done) begin
                done_seen = 1'b1;
                chk("xfer_count", ntr, vh.size());
                chk("start_count", nstart, fh.size());
                i_start = 1'b1;
            end else begin
                i_start = ($urandom_range(99, 0) < 20);
            end
            i_height = 7'($urandom_range(20, 1));
            i_width  = 7'($urandom_range(20, 1));
            i_stride = 3'($urandom_range(7, 0));
            tick();
            cyc++;
        end

        chk("done_within_budget", done_seen, 1);
        chk("idle_after_done", o_busy, 0);
        chk("done_single_pulse", o_done, 0);
        i_start     = 1'b0;
        i_pos_ready = 1'b0;
        i_rf_finish = 1'b0;
        tick();
    endtask

    initial begin
        int guard;

        i_rst_n     = 1'b0;
        i_start     = 1'b0;
        i_height    = '0;
        i_width     = '0;
        i_stride    = '0;
        i_rf_finish = 1'b0;
        i_pos_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_rf_start", o_rf_start, 0);
        chk("rst_valid", o_pos_valid, 0);
        chk("rst_h", o_rf_h, 0);
        chk("rst_w", o_rf_w, 0);
        chk("rst_idx", o_pos_idx, 0);
        chk("rst_timeout", o_timeout, 0);
        i_rst_n = 1'b1;
        tick();
        tick();
        chk("idle_after_rst", o_busy, 0);

        // Asynchronous reset while waiting for a fetch
        i_height = 7'd2;
        i_width  = 7'd2;
        i_stride = 3'd1;
        i_start  = 1'b1;
        tick();
        i_start = 1'b0;
        guard = 0;
        while (!o_rf_start && guard < 20) begin
            tick();
            guard++;
        end
        chk("mid_rst_saw_start", o_rf_start, 1);
        tick();
        chk("mid_rst_in_wait", o_busy, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async_busy", o_busy, 0);
        chk("async_valid", o_pos_valid, 0);
        chk("async_rf_start", o_rf_start, 0);
        chk("async_done", o_done, 0);
        chk("async_h", o_rf_h, 0);
        chk("async_w", o_rf_w, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("held_rst_done", o_done, 0);
        end
        #3;
        i_rst_n = 1'b1;
        tick();
        chk("post_rst_idle", o_busy, 0);
        chk("post_rst_no_done", o_done, 0);

        // Directed frames
        run_frame(3, 4, 1, 100, -1, 3);
        run_frame(10, 11, 2, 100, -1, 2);
        run_frame(3, 3, 1, 30, -1, 3);
        run_frame(0, 5, 1, 100, -1, 1);
        run_frame(4, 0, 2, 100, -1, 1);
        run_frame(2, 2, 0, 100, -1, 1);
        run_frame(7, 5, 7, 50, -1, 4);
        run_frame(1, 1, 1, 100, -1, 1);

`ifdef ADDR_RF_SCHED_TIMEOUT_EN
        run_frame(1, 4, 1, 100, 1, 2);
        run_frame(3, 3, 2, 60, 3, 3);
`endif

        // Random frames
        for (int n = 0; n < 12; n++) begin
            run_frame($urandom_range(9, 0), $urandom_range(9, 0), $urandom_range(4, 0),
                      $urandom_range(100, 20), -1, $urandom_range(4, 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
